// File: rtl/mult_hilo_ctrl.sv
// Sequencer for the iterative multiplier plus the HI/LO register pair.
// Issues load, STEPS steps and a capture cycle per accepted start.
module mult_hilo_ctrl #(
  parameter int STEPS = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] mult_multiplier,
  output logic [31:0] mult_multiplicand,
  output logic [1:0]  mult_select,
  input  logic [31:0] product0,
  input  logic [31:0] product1,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STEP,
    CAPTURE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_step;

  assign accept    = (state == IDLE) && start;
  assign last_step = (cnt == CNT_W'(1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    mult_select = 2'b00;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        mult_select = 2'b01;
        state_nxt   = STEP;
      end
      STEP: begin
        mult_select = 2'b10;
        if (last_step) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == CAPTURE);
      if (state == LOAD)
        cnt <= CNT_W'(STEPS);
      else if (state == STEP)
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mult_multiplier   <= '0;
      mult_multiplicand <= '0;
    end else if (accept) begin
      mult_multiplier   <= rs_data;
      mult_multiplicand <= rt_data;
    end
  end

  // Software writes only land in a quiet IDLE cycle; start takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == CAPTURE) begin
      lo <= product0;
      hi <= product1;
    end else if (state == IDLE && !start) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
- Sequencer and HI/LO register holder that sits directly upstream and downstream of the iterative 32-bit multiplier datapath.
- Accepts a multiply request from the CPU control unit and latches the operands.
- Drives the multiplier's 2-bit select (01 = load, 10 = step) for the required cycle count, then captures product0/product1 into LO/HI.
- Provides busy/done to stall the pipeline, plus mthi/mtlo writes and HI/LO read ports.

Parameters:
- STEPS, 32: number of select=10 step cycles issued per multiply; must equal the multiplier operand width.
- CNT_W, 6: width of the internal step counter; must hold STEPS.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  multiply request, sampled on rising edge
- rs_data  input  32  multiplier operand
- rt_data  input  32  multiplicand operand
- mthi  input  1  write wdata into HI
- mtlo  input  1  write wdata into LO
- wdata  input  32  data for mthi/mtlo
- mult_multiplier  output  32  to multiplier.multiplier, registered
- mult_multiplicand  output  32  to multiplier.multiplicand, registered
- mult_select  output  2  to multiplier.select
- product0  input  32  from multiplier, low word
- product1  input  32  from multiplier, high word
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  high while a multiply is in flight
- done  output  1  one-cycle pulse when hi/lo hold a new product

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; hi, lo, mult_multiplier, mult_multiplicand = 0; mult_select = 00; busy = 0; done = 0; counter = 0.
- State machine: IDLE, LOAD, STEP, CAPTURE. All outputs are registered or decoded from state; no combinational path from any input to any output.
- IDLE
  - select = 00, busy = 0.
  - On edge E0 with start = 1: latch rs_data -> mult_multiplier and rt_data -> mult_multiplicand, then go to LOAD.
- LOAD (one cycle): select = 01, busy = 1. The multiplier initialises on the closing edge. Counter loads STEPS; go to STEP.
- STEP: select = 10, busy = 1. Counter decrements each edge; after STEPS cycles go to CAPTURE. This gives 32 step edges in total, E0+2 .. E0+33.
- CAPTURE (one cycle): select = 00, busy = 1. On the closing edge E0+34: lo <= product0, hi <= product1, done <= 1; go to IDLE.
- Latency: start at E0 -> hi/lo valid and done high in the cycle after E0+34. Busy is high for exactly 34 cycles.
- done: high for exactly one cycle. It clears on the next edge even if start is high.
- start when busy = 1: ignored; no queuing.
- start asserted in the same cycle done is high: accepted (state is IDLE); back-to-back multiplies are legal.
- Operand outputs: held constant from E0 until the next accepted start.
- mthi/mtlo
  - In IDLE: update hi/lo on the edge, with no effect on done.
  - While busy: dropped.
  - Same edge as an accepted start: start wins and the write is dropped.
  - mthi and mtlo together: both registers are written with wdata.
- product0/product1: only sampled in CAPTURE. Values at any other time, including the X after power-up, never reach hi/lo.
- Reset mid-operation: immediate return to IDLE with all outputs as at reset. Any residual iteration state in the multiplier is harmless because the next LOAD reinitialises it.
- Signedness is a property of the multiplier instance; this block passes operands unmodified.

Test Plan:
- Reset release, then start with rs = 7, rt = 6 -> select = 01 for 1 cycle, then 10 for 32 cycles, then 00. lo = 0x0000002A, hi = 0, done pulses once at E0+34, busy high for 34 cycles.
- Signed instance, rs = 0xFFFFFFFD (-3), rt = 5 -> lo = 0xFFFFFFF1, hi = 0xFFFFFFFF.
- Signed instance, rs = rt = 0xFFFFFFFF -> lo = 1, hi = 0. Then a back-to-back start in the done cycle with rs = 0x10000, rt = 0x10000 -> lo = 0, hi = 1.
- mthi 0xDEADBEEF in IDLE -> hi = 0xDEADBEEF.
- Start, then mtlo 0x1234 and a second start at step 5 -> both ignored; lo = final product only.
- reset_n low at step 10 -> hi = lo = 0, select = 00, busy = 0 immediately. After release, start rs = 3, rt = 4 -> lo = 12 at E0+34.
